// File: rtl/asteroid_pkg.sv
// asteroid_pkg: shared FSM states, LFSR constants and invulnerability length for the asteroid scheduler
package asteroid_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, HIT, OVER} state_t;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int INVULN_FRAMES = 60;
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? (v >> 1) ^ LFSR_TAPS : v >> 1;
    endfunction
endpackage

// File: rtl/asteroid_pixel_mux.sv
// asteroid_pixel_mux: registered fixed-priority merge of asteroid pixels, lowest index wins
module asteroid_pixel_mux #(
    parameter int N = 10,
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   ast_drawing,
    input  logic [N*W-1:0] ast_pixel,
    output logic [W-1:0]   pixel,
    output logic           drawing
);
    logic [W-1:0] pix;
    always_comb begin
        pix = '0;
        for (int i = N - 1; i >= 0; i--)
            pix = ast_drawing[i] ? ast_pixel[i*W +: W] : pix;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel <= '0;
            drawing <= 1'b0;
        end else begin
            pixel <= pix;
            drawing <= |ast_drawing;
        end
    end
endmodule

// File: rtl/asteroid_scheduler.sv
// asteroid_scheduler: game FSM, kill/score/speed bookkeeping and asteroid layer merge.
// Define ASTEROID_SCHED_INVULN_EN to hold HIT for INVULN_FRAMES frames with ship collisions ignored.
module asteroid_scheduler
    import asteroid_pkg::*;
#(
    parameter int ASTEROID_COUNT = 10,
    parameter int COLR_BITS      = 4,
    parameter int KILLS_PER_WAVE = 16,
    parameter int MAX_SPEED      = 8,
    parameter int START_LIVES    = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame,
    input  logic                          start,
    input  logic [ASTEROID_COUNT-1:0]     ast_drawing,
    input  logic [ASTEROID_COUNT*COLR_BITS-1:0] ast_pixel,
    input  logic                          bullet_drawing,
    input  logic                          ship_drawing,
    output logic [ASTEROID_COUNT-1:0]     shot,
    output logic [7:0]                    speed,
    output logic [15:0]                   rand_factor,
    output logic [COLR_BITS-1:0]          pixel,
    output logic                          drawing,
    output logic [15:0]                   score,
    output logic [1:0]                    lives,
    output logic                          game_over
);
    state_t state;
    logic [15:0] kill_cnt, kills_now, kc_sum;
    logic [16:0] score_sum;
    logic [ASTEROID_COUNT-1:0] shot_base, hits;
    logic start_q, collide;

    asteroid_pixel_mux #(.N(ASTEROID_COUNT), .W(COLR_BITS)) u_mux (
        .clk(clk), .rst(rst), .ast_drawing(ast_drawing), .ast_pixel(ast_pixel),
        .pixel(pixel), .drawing(drawing)
    );

    // a frame pulse retires the old frame's flags before this cycle's hits are merged in
    always_comb begin
        shot_base = frame ? '0 : shot;
        hits = bullet_drawing ? ast_drawing & ~shot_base : '0;
        kills_now = '0;
        for (int i = 0; i < ASTEROID_COUNT; i++)
            kills_now = kills_now + 16'(hits[i]);
        score_sum = {1'b0, score} + {1'b0, kills_now};
        kc_sum = kill_cnt + kills_now;
        collide = state == PLAY && ship_drawing && |ast_drawing;
    end

    assign game_over = state == OVER;

`ifdef ASTEROID_SCHED_INVULN_EN
    logic [6:0] inv_cnt;
    logic hit_done;
    always_ff @(posedge clk)
        inv_cnt <= rst || state != HIT ? '0 : inv_cnt + 7'(frame);
    assign hit_done = inv_cnt == 7'(INVULN_FRAMES - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            score <= '0;
            lives <= '0;
            speed <= '0;
            shot <= '1;
            kill_cnt <= '0;
            start_q <= 1'b0;
            rand_factor <= LFSR_SEED;
        end else begin
            rand_factor <= lfsr_next(rand_factor);
            start_q <= start;
            case (state)
                IDLE: if (start) begin
                    state <= PLAY;
                    score <= '0;
                    lives <= 2'(START_LIVES);
                    speed <= 8'd1;
                    kill_cnt <= '0;
                end
                OVER: if (start && !start_q) state <= IDLE;
                default: begin
                    shot <= shot_base | hits;
                    score <= score_sum[16] ? '1 : score_sum[15:0];
                    kill_cnt <= kc_sum >= 16'(KILLS_PER_WAVE) ? kc_sum - 16'(KILLS_PER_WAVE) : kc_sum;
                    if (kc_sum >= 16'(KILLS_PER_WAVE) && speed < 8'(MAX_SPEED))
                        speed <= speed + 8'd1;
                    if (collide) begin
                        lives <= lives - 2'd1;
                        state <= lives == 2'd1 ? OVER : HIT;
                        if (lives == 2'd1) begin
                            speed <= '0;
                            shot <= '1;
                        end
                    end else if (state == HIT && frame)
`ifdef ASTEROID_SCHED_INVULN_EN
                        state <= hit_done ? PLAY : HIT;
`else
                        state <= PLAY;
`endif
                end
            endcase
        end
    end
endmodule
